// File: rtl/calc_io_pkg.sv
// Shared constants for the calculator input front end: button indices,
// conversion FSM encoding and the BCD digit clamp helper.
package calc_io_pkg;

  localparam int BTN_EQ  = 0;
  localparam int BTN_MUL = 1;
  localparam int BTN_SUB = 2;
  localparam int BTN_ADD = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Out-of-range BCD digits are saturated so the accumulator stays bounded.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : digit;
  endfunction

endpackage

// File: rtl/calc_btn_debounce.sv
// One button lane: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle rise pulse that coincides with the level going high.
module calc_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic             raw_meta;
  logic             raw_sync;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      raw_meta <= 1'b0;
      raw_sync <= 1'b0;
      cnt      <= '0;
      level    <= 1'b0;
      rise     <= 1'b0;
    end else begin
      raw_meta <= raw;
      raw_sync <= raw_meta;
      rise     <= 1'b0;
      if (raw_sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= raw_sync;
        rise  <= raw_sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_input_capture.sv
// Calculator input front end: debounced operator buttons with sticky events
// and BCD-switch to binary conversion. Optional repeat: CALC_IN_AUTOREPEAT_EN.
module calc_input_capture
  import calc_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int REPEAT_CYCLES   = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  btn_raw,
  input  logic [15:0] sw,
  input  logic        rd_evt,
  output logic [3:0]  btn_evt,
  output logic [3:0]  btn_level,
  output logic [15:0] bin_out,
  output logic        bin_valid,
  output logic        bin_busy,
  output logic        bcd_err
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("calc_input_capture: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  logic [3:0] rise;
  logic [3:0] evt_set;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    calc_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .rise (rise[i])
    );
  end

`ifdef CALC_IN_AUTOREPEAT_EN
  logic [3:0]       level_q;
  logic [CNT_W-1:0] rep_cnt;
  logic             level_steady;
  logic             rep_due;

  assign level_steady = (btn_level == level_q);
  assign rep_due      = level_steady && (rep_cnt == CNT_W'(REPEAT_CYCLES - 1));

  // One shared period counter; any press or release restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      rep_cnt <= '0;
    end else begin
      level_q <= btn_level;
      if (!level_steady || btn_level == 4'b0000 || rep_due) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  // NOTE: combinational outputs get a default first so no latch is inferred.
  always_comb begin
    evt_set = rise;
    if (rep_due) evt_set = rise | btn_level;
  end
`else
  always_comb begin
    evt_set = rise;
  end
`endif

  // Read clears what it returns; a set arriving in the same cycle survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_evt <= '0;
    end else begin
      btn_evt <= (rd_evt ? 4'b0000 : btn_evt) | evt_set;
    end
  end

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [15:0] sw_last;
  logic [15:0] snap;
  logic [1:0]  state;
  logic [1:0]  idx;
  logic [13:0] acc;
  logic        err_acc;
  logic [3:0]  digit;
  logic [3:0]  digit_sat;

  assign digit     = snap[{idx, 2'b00} +: 4];
  assign digit_sat = bcd_clamp(digit);
  assign bin_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta   <= '0;
      sw_sync   <= '0;
      sw_last   <= '0;
      snap      <= '0;
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      err_acc   <= 1'b0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      bcd_err   <= 1'b0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      case (state)
        IDLE: begin
          if (sw_sync != sw_last) begin
            snap    <= sw_sync;
            sw_last <= sw_sync;
            acc     <= '0;
            idx     <= 2'd3;
            err_acc <= 1'b0;
            state   <= CONV;
          end
        end
        CONV: begin
          acc <= (acc << 3) + (acc << 1) + {10'd0, digit_sat};
          if (digit > BCD_MAX_DIGIT) err_acc <= 1'b1;
          if (idx == 2'd0) begin
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          bin_out   <= {2'b00, acc};
          bcd_err   <= err_acc;
          bin_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_input_capture.sv
// Self-checking bench for calc_input_capture: table-driven BCD conversions
// through a scoreboard plus hand-written button/event sequences.
module tb_calc_input_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn_raw;
  logic [15:0] sw;
  logic        rd_evt;
  logic [3:0]  btn_evt;
  logic [3:0]  btn_level;
  logic [15:0] bin_out;
  logic        bin_valid;
  logic        bin_busy;
  logic        bcd_err;

  calc_input_capture dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .sw       (sw),
    .rd_evt   (rd_evt),
    .btn_evt  (btn_evt),
    .btn_level(btn_level),
    .bin_out  (bin_out),
    .bin_valid(bin_valid),
    .bin_busy (bin_busy),
    .bcd_err  (bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sw;
    logic [15:0] bin;
    logic        err;
  } conv_vec_t;

  typedef struct packed {
    logic [15:0] bin;
    logic        err;
  } exp_t;

  exp_t      sb[$];
  conv_vec_t vecs[8];
  int        checks   = 0;
  int        failures = 0;
  logic      busy_q   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Conversion completes when busy drops; bin_out is updated on that edge.
  always @(negedge clk) begin
    if (busy_q && !bin_busy) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_conv: got bin_out=%0d with no expected entry", bin_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_bin_out", {16'd0, bin_out}, {16'd0, e.bin});
        check("sb_bcd_err", {31'd0, bcd_err}, {31'd0, e.err});
        check("sb_bin_valid", {31'd0, bin_valid}, 32'd1);
      end
    end
    busy_q = bin_busy;
  end

  task automatic wait_sb(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int evt_count;
    int exp_count;

    vecs[0] = '{16'h9999, 16'd9999, 1'b0};
    vecs[1] = '{16'h12A4, 16'd1294, 1'b1};
    vecs[2] = '{16'h0000, 16'd0,    1'b0};
    vecs[3] = '{16'h0007, 16'd7,    1'b0};
    vecs[4] = '{16'hFFFF, 16'd9999, 1'b1};
    vecs[5] = '{16'h5060, 16'd5060, 1'b0};
    vecs[6] = '{16'h0A00, 16'd900,  1'b1};
    vecs[7] = '{16'h0100, 16'd100,  1'b0};

    // Reset held with switches set and all buttons pressed.
    reset   = 1'b1;
    btn_raw = 4'hF;
    sw      = 16'h1234;
    rd_evt  = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_outputs",
          {3'd0, btn_evt, btn_level, bin_out, bin_valid, bin_busy, bcd_err}, 32'd0);

    sb.push_back('{16'd1234, 1'b0});
    reset   = 1'b0;
    btn_raw = 4'h0;
    n = 0;
    while (!bin_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reset_conv_within_8", (n <= 8) ? 32'd1 : 32'd0, 32'd1);
    check("reset_conv_value", {16'd0, bin_out}, 32'h04D2);
    wait_sb("reset_conv_sb", 5);

    foreach (vecs[k]) begin
      sw = vecs[k].sw;
      sb.push_back('{vecs[k].bin, vecs[k].err});
      wait_sb($sformatf("tbl_conv_%0d", k), 40);
      repeat (2) @(negedge clk);
    end

    // Switch change during CONV: first result unaffected, second follows.
    sw = 16'h0011;
    sb.push_back('{16'd11, 1'b0});
    n = 0;
    while (!bin_busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("conv_started", {31'd0, bin_busy}, 32'd1);
    repeat (2) @(negedge clk);
    sw = 16'h0022;
    sb.push_back('{16'd22, 1'b0});
    wait_sb("conv_during_conv", 60);

    rd_evt = 1'b1;
    @(negedge clk);
    rd_evt = 1'b0;
    check("evt_clear_before_btn", {28'd0, btn_evt}, 32'd0);

    btn_raw[3] = 1'b1;
    repeat (8) @(negedge clk);
    check("add_level", {28'd0, btn_level}, 32'h8);
    check("add_evt", {28'd0, btn_evt}, 32'h8);

    btn_raw[1] = 1'b1;
    repeat (2) @(negedge clk);
    btn_raw[1] = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch_level", {28'd0, btn_level}, 32'h8);
    check("glitch_evt", {28'd0, btn_evt}, 32'h8);

    // New eq edge coincides with a read: old bit cleared, new bit kept.
    btn_raw[0] = 1'b1;
    n = 0;
    while (!btn_level[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("eq_latency", n, 32'd6);
    rd_evt = 1'b1;
    @(negedge clk);
    rd_evt = 1'b0;
    check("rd_with_edge", {28'd0, btn_evt}, 32'h1);
    rd_evt = 1'b1;
    @(negedge clk);
    rd_evt = 1'b0;
    check("rd_clear", {28'd0, btn_evt}, 32'h0);

    btn_raw = 4'h0;
    repeat (10) @(negedge clk);
    check("release_level", {28'd0, btn_level}, 32'h0);
    check("release_no_evt", {28'd0, btn_evt}, 32'h0);

    // eq held 100 cycles with a read every cycle.
    btn_raw[0] = 1'b1;
    rd_evt     = 1'b1;
    evt_count  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (btn_evt[0]) evt_count++;
    end
    btn_raw[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (btn_evt[0]) evt_count++;
    end
    rd_evt = 1'b0;
`ifdef CALC_IN_AUTOREPEAT_EN
    exp_count = 1 + (100 - 1) / 25;
`else
    exp_count = 1;
`endif
    check("hold_event_count", evt_count, exp_count);
    check("hold_end_evt", {28'd0, btn_evt}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
